// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter (CPU / DMA) for the shared DRAM slave port.
// Round-robin grant with CPU parking, grant frozen during fixed-length bursts and locked sequences.
module ahb_master_arbiter #(
  parameter int BURST_CNT_W = 5
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hready,
  input  logic        hbusreq_cpu,
  input  logic        hbusreq_dma,
  input  logic        hlock_cpu,
  input  logic        hlock_dma,
  input  logic [31:0] haddr_cpu,
  input  logic [31:0] haddr_dma,
  input  logic [1:0]  htrans_cpu,
  input  logic [1:0]  htrans_dma,
  input  logic [2:0]  hburst_cpu,
  input  logic [2:0]  hburst_dma,
  input  logic [2:0]  hsize_cpu,
  input  logic [2:0]  hsize_dma,
  input  logic [3:0]  hprot_cpu,
  input  logic [3:0]  hprot_dma,
  input  logic        hwrite_cpu,
  input  logic        hwrite_dma,
  input  logic [31:0] hwdata_cpu,
  input  logic [31:0] hwdata_dma,
  output logic        hgrant_cpu,
  output logic        hgrant_dma,
  output logic        hmaster,
  output logic        hmaster_data,
  output logic        hmastlock_o,
  output logic [31:0] haddr_o,
  output logic [1:0]  htrans_o,
  output logic [2:0]  hburst_o,
  output logic [2:0]  hsize_o,
  output logic [3:0]  hprot_o,
  output logic        hwrite_o,
  output logic [31:0] hwdata_o
);

  typedef enum logic [1:0] {ARB, BURST, LOCK} state_t;

  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  state_t                 state_reg, state_next;
  logic [BURST_CNT_W-1:0] count_reg, count_next;
  logic                   grant_reg, grant_next;   // 1 = DMA
  logic                   hmaster_reg;
  logic                   hmaster_data_reg;
  logic                   mastlock_reg;
  logic                   last_reg;                // last address-phase owner
  logic                   rearb;

  logic [1:0]             own_trans;
  logic [2:0]             own_burst;
  logic                   own_lock;
  logic [BURST_CNT_W-1:0] len_m1;
  logic                   fixed_len;

  assign own_trans = hmaster_reg ? htrans_dma : htrans_cpu;
  assign own_burst = hmaster_reg ? hburst_dma : hburst_cpu;
  assign own_lock  = hmaster_reg ? hlock_dma  : hlock_cpu;

  always_comb begin
    len_m1 = '0;
    case (own_burst)
      3'b010, 3'b011: len_m1 = BURST_CNT_W'(3);
      3'b100, 3'b101: len_m1 = BURST_CNT_W'(7);
      3'b110, 3'b111: len_m1 = BURST_CNT_W'(15);
      default:        len_m1 = '0;
    endcase
  end

  assign fixed_len = (len_m1 != '0);

  // Lock wins over burst; rearb marks edges where the grant may move.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    rearb      = 1'b0;
    if (own_lock) begin
      state_next = LOCK;
    end else begin
      case (state_reg)
        LOCK: begin
          state_next = ARB;
          count_next = '0;
          rearb      = 1'b1;
        end
        BURST: begin
          if (own_trans == TRANS_NONSEQ) begin
            if (fixed_len) begin
              count_next = len_m1;
            end else begin
              state_next = ARB;
              count_next = '0;
              rearb      = 1'b1;
            end
          end else if (own_trans == TRANS_SEQ) begin
            if (count_reg <= BURST_CNT_W'(1)) begin
              state_next = ARB;
              count_next = '0;
              rearb      = 1'b1;
            end else begin
              count_next = count_reg - BURST_CNT_W'(1);
            end
          end
        end
        default: begin
          if (own_trans == TRANS_NONSEQ && fixed_len) begin
            state_next = BURST;
            count_next = len_m1;
          end else begin
            rearb = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    grant_next = grant_reg;
    if (rearb) begin
      case ({hbusreq_dma, hbusreq_cpu})
        2'b11:   grant_next = ~last_reg;
        2'b10:   grant_next = 1'b1;
        default: grant_next = 1'b0;   // CPU only, or park on CPU
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_reg        <= ARB;
      count_reg        <= '0;
      grant_reg        <= 1'b0;
      hmaster_reg      <= 1'b0;
      hmaster_data_reg <= 1'b0;
      mastlock_reg     <= 1'b0;
      last_reg         <= 1'b0;
    end else if (hready) begin
      state_reg        <= state_next;
      count_reg        <= count_next;
      grant_reg        <= grant_next;
      hmaster_reg      <= grant_reg;
      hmaster_data_reg <= hmaster_reg;
      mastlock_reg     <= own_lock;
      if (hmaster_reg != grant_reg) begin
        last_reg <= grant_reg;
      end
    end
  end

  assign hgrant_cpu   = ~grant_reg;
  assign hgrant_dma   = grant_reg;
  assign hmaster      = hmaster_reg;
  assign hmaster_data = hmaster_data_reg;
  assign hmastlock_o  = mastlock_reg;

  assign haddr_o  = hmaster_reg ? haddr_dma  : haddr_cpu;
  assign htrans_o = hmaster_reg ? htrans_dma : htrans_cpu;
  assign hburst_o = hmaster_reg ? hburst_dma : hburst_cpu;
  assign hsize_o  = hmaster_reg ? hsize_dma  : hsize_cpu;
  assign hprot_o  = hmaster_reg ? hprot_dma  : hprot_cpu;
  assign hwrite_o = hmaster_reg ? hwrite_dma : hwrite_cpu;
  assign hwdata_o = hmaster_data_reg ? hwdata_dma : hwdata_cpu;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Scoreboard bench for ahb_master_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_ahb_master_arbiter;

  logic        hclk = 1'b0;
  logic        hreset, hready;
  logic        hbusreq_cpu, hbusreq_dma, hlock_cpu, hlock_dma;
  logic [31:0] haddr_cpu, haddr_dma;
  logic [1:0]  htrans_cpu, htrans_dma;
  logic [2:0]  hburst_cpu, hburst_dma, hsize_cpu, hsize_dma;
  logic [3:0]  hprot_cpu, hprot_dma;
  logic        hwrite_cpu, hwrite_dma;
  logic [31:0] hwdata_cpu, hwdata_dma;
  logic        hgrant_cpu, hgrant_dma, hmaster, hmaster_data, hmastlock_o;
  logic [31:0] haddr_o, hwdata_o;
  logic [1:0]  htrans_o;
  logic [2:0]  hburst_o, hsize_o;
  logic [3:0]  hprot_o;
  logic        hwrite_o;

  ahb_master_arbiter #(.BURST_CNT_W(5)) dut (
    .hclk(hclk), .hreset(hreset), .hready(hready),
    .hbusreq_cpu(hbusreq_cpu), .hbusreq_dma(hbusreq_dma),
    .hlock_cpu(hlock_cpu), .hlock_dma(hlock_dma),
    .haddr_cpu(haddr_cpu), .haddr_dma(haddr_dma),
    .htrans_cpu(htrans_cpu), .htrans_dma(htrans_dma),
    .hburst_cpu(hburst_cpu), .hburst_dma(hburst_dma),
    .hsize_cpu(hsize_cpu), .hsize_dma(hsize_dma),
    .hprot_cpu(hprot_cpu), .hprot_dma(hprot_dma),
    .hwrite_cpu(hwrite_cpu), .hwrite_dma(hwrite_dma),
    .hwdata_cpu(hwdata_cpu), .hwdata_dma(hwdata_dma),
    .hgrant_cpu(hgrant_cpu), .hgrant_dma(hgrant_dma),
    .hmaster(hmaster), .hmaster_data(hmaster_data), .hmastlock_o(hmastlock_o),
    .haddr_o(haddr_o), .htrans_o(htrans_o), .hburst_o(hburst_o),
    .hsize_o(hsize_o), .hprot_o(hprot_o), .hwrite_o(hwrite_o),
    .hwdata_o(hwdata_o)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic        gc, gd, m, md, lk;
    logic [31:0] addr;
    logic [12:0] ctrl;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: who owns what, and how many beats of the current burst remain.
  localparam int M_ARB = 0, M_BURST = 1, M_LOCK = 2;
  int m_grant, m_master, m_mdata, m_lock, m_mode, m_left;

  function automatic int beats(input logic [2:0] b);
    return (b < 3'd2) ? 0 : (2 << (b >> 1));
  endfunction

  task automatic model_edge();
    logic [1:0] tr;
    logic [2:0] bu;
    logic       lk;
    int         arb, new_grant;
    if (hreset) begin
      m_grant = 0; m_master = 0; m_mdata = 0; m_lock = 0; m_mode = M_ARB; m_left = 0;
      return;
    end
    if (!hready) return;
    tr  = (m_master == 1) ? htrans_dma : htrans_cpu;
    bu  = (m_master == 1) ? hburst_dma : hburst_cpu;
    lk  = (m_master == 1) ? hlock_dma  : hlock_cpu;
    arb = 0;
    if (lk) m_mode = M_LOCK;
    else if (m_mode == M_LOCK) begin
      m_mode = M_ARB; arb = 1;
    end else if (m_mode == M_BURST) begin
      if (tr == 2'b10) begin
        if (beats(bu) > 0) m_left = beats(bu) - 1;
        else begin m_mode = M_ARB; arb = 1; end
      end else if (tr == 2'b11) begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_mode = M_ARB; arb = 1; end
      end
    end else if (tr == 2'b10 && beats(bu) > 0) begin
      m_mode = M_BURST; m_left = beats(bu) - 1;
    end else arb = 1;
    new_grant = m_grant;
    if (arb == 1) begin
      // The last owner is whoever currently holds the address phase.
      if (hbusreq_cpu && hbusreq_dma) new_grant = 1 - m_master;
      else new_grant = hbusreq_dma ? 1 : 0;
    end
    m_mdata  = m_master;
    m_master = m_grant;
    m_grant  = new_grant;
    m_lock   = lk ? 1 : 0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.gc    = (m_grant == 0);
    e.gd    = (m_grant == 1);
    e.m     = (m_master == 1);
    e.md    = (m_mdata == 1);
    e.lk    = (m_lock == 1);
    e.addr  = (m_master == 1) ? haddr_dma : haddr_cpu;
    e.ctrl  = (m_master == 1) ? {htrans_dma, hburst_dma, hsize_dma, hprot_dma, hwrite_dma}
                              : {htrans_cpu, hburst_cpu, hsize_cpu, hprot_cpu, hwrite_cpu};
    e.wdata = (m_mdata == 1) ? hwdata_dma : hwdata_cpu;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge hclk);
    model_edge();
    #1;
  endtask

  task automatic step();
    push_exp();
    tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge hclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hgrant", {30'd0, hgrant_cpu, hgrant_dma}, {30'd0, e.gc, e.gd});
        chk("hmaster", {31'd0, hmaster}, {31'd0, e.m});
        chk("hmaster_data", {31'd0, hmaster_data}, {31'd0, e.md});
        chk("hmastlock_o", {31'd0, hmastlock_o}, {31'd0, e.lk});
        chk("haddr_o", haddr_o, e.addr);
        chk("ctrl_o", {19'd0, htrans_o, hburst_o, hsize_o, hprot_o, hwrite_o}, {19'd0, e.ctrl});
        chk("hwdata_o", hwdata_o, e.wdata);
      end
    end
  end

  task automatic idle_inputs();
    hready = 1'b1;
    hbusreq_cpu = 1'b0; hbusreq_dma = 1'b0; hlock_cpu = 1'b0; hlock_dma = 1'b0;
    haddr_cpu = 32'h0000_1000; haddr_dma = 32'h0000_0000;
    htrans_cpu = 2'b00; htrans_dma = 2'b00;
    hburst_cpu = 3'b000; hburst_dma = 3'b000;
    hsize_cpu = 3'b010; hsize_dma = 3'b010;
    hprot_cpu = 4'b0011; hprot_dma = 4'b0001;
    hwrite_cpu = 1'b0; hwrite_dma = 1'b1;
    hwdata_cpu = 32'hC0C0_0000; hwdata_dma = 32'hD0D0_0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    hreset = 1'b1;
    step();
    hreset = 1'b0;
  endtask

  task automatic rand_inputs();
    hreset      = ($urandom_range(99) == 0);
    hready      = ($urandom_range(4) != 0);
    hbusreq_cpu = 1'($urandom_range(1));
    hbusreq_dma = 1'($urandom_range(1));
    hlock_cpu   = ($urandom_range(9) == 0);
    hlock_dma   = ($urandom_range(9) == 0);
    haddr_cpu   = $urandom;
    haddr_dma   = $urandom;
    htrans_cpu  = 2'($urandom_range(3));
    htrans_dma  = 2'($urandom_range(3));
    hburst_cpu  = 3'($urandom_range(7));
    hburst_dma  = 3'($urandom_range(7));
    hsize_cpu   = 3'($urandom_range(7));
    hsize_dma   = 3'($urandom_range(7));
    hprot_cpu   = 4'($urandom_range(15));
    hprot_dma   = 4'($urandom_range(15));
    hwrite_cpu  = 1'($urandom_range(1));
    hwrite_dma  = 1'($urandom_range(1));
    hwdata_cpu  = $urandom;
    hwdata_dma  = $urandom;
  endtask

  initial begin
    m_grant = 0; m_master = 0; m_mdata = 0; m_lock = 0; m_mode = M_ARB; m_left = 0;
    idle_inputs();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;

    $display("txn: reset idle, CPU parked at 0x00001000");
    for (int i = 0; i < 3; i++) step();

    $display("txn: both request from idle, DMA undefined-length INCR");
    hbusreq_cpu = 1'b1; hbusreq_dma = 1'b1;
    step(); step();
    htrans_dma = 2'b10; hburst_dma = 3'b001; haddr_dma = 32'h3000_0000;
    for (int i = 0; i < 4; i++) begin step(); htrans_dma = 2'b11; haddr_dma += 4; end

    $display("txn: DMA INCR8 at 0x20000000 with CPU requesting");
    do_reset();
    hbusreq_dma = 1'b1;
    step(); step();
    hbusreq_cpu = 1'b1;
    htrans_dma = 2'b10; hburst_dma = 3'b101; haddr_dma = 32'h2000_0000; hwdata_dma = $urandom;
    step();
    for (int i = 1; i < 8; i++) begin
      htrans_dma = 2'b11; haddr_dma += 4; hwdata_dma = $urandom; hwdata_cpu = $urandom;
      step();
    end
    htrans_dma = 2'b00; hbusreq_dma = 1'b0; hwdata_dma = $urandom;
    for (int i = 0; i < 4; i++) begin hwdata_cpu = $urandom; step(); end

    $display("txn: CPU INCR4 with two stall cycles on beat 2, DMA requesting");
    do_reset();
    hbusreq_cpu = 1'b1; hbusreq_dma = 1'b1;
    htrans_cpu = 2'b10; hburst_cpu = 3'b011; haddr_cpu = 32'h0000_4000;
    step();
    htrans_cpu = 2'b11; haddr_cpu += 4;
    hready = 1'b0; step(); step();
    hready = 1'b1; step();
    haddr_cpu += 4; step();
    haddr_cpu += 4; step();
    htrans_cpu = 2'b00; hbusreq_cpu = 1'b0;
    for (int i = 0; i < 3; i++) step();

    $display("txn: CPU locked sequence of 3 transfers, DMA requesting");
    do_reset();
    hbusreq_cpu = 1'b1; hbusreq_dma = 1'b1; hlock_cpu = 1'b1;
    htrans_cpu = 2'b10; hburst_cpu = 3'b000;
    for (int i = 0; i < 3; i++) begin step(); haddr_cpu += 4; end
    hlock_cpu = 1'b0; htrans_cpu = 2'b00;
    for (int i = 0; i < 4; i++) step();

    $display("txn: CPU INCR16 reset at beat 7");
    do_reset();
    hbusreq_cpu = 1'b1; hbusreq_dma = 1'b1; hlock_cpu = 1'b1;
    htrans_cpu = 2'b10; hburst_cpu = 3'b111; haddr_cpu = 32'h0000_8000;
    step();
    hlock_cpu = 1'b0;
    for (int i = 1; i < 6; i++) begin htrans_cpu = 2'b11; haddr_cpu += 4; step(); end
    hready = 1'b0; haddr_cpu += 4; hreset = 1'b1;
    step();
    hreset = 1'b0; hready = 1'b1; hbusreq_cpu = 1'b0; hbusreq_dma = 1'b0; htrans_cpu = 2'b00;
    for (int i = 0; i < 3; i++) step();

    $display("txn: random traffic, 3000 cycles");
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    idle_inputs();
    hreset = 1'b0;
    @(negedge hclk);
    #1;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Two-master AHB-Lite arbiter that shares the DRAM slave port between the CPU and the DMA engine's bus master. It grants the bus round-robin and parks on the CPU when idle. It holds the grant for fixed-length bursts and locked sequences. It muxes the owner's address/control in the address phase and the owner's write data in the data phase. It sits between the two master ports and the DRAM-side decode, downstream of the CPU-side address split.

## Interface
Parameters:
- BURST_CNT_W, default 5: width of the beat counter; must hold 16.

Ports:
- hclk  in  1  bus clock; all state updates on its rising edge.
- hreset  in  1  synchronous, active-high reset.
- hready  in  1  shared slave ready; low stalls everything.
- hbusreq_cpu, hbusreq_dma  in  1  bus request per master.
- hlock_cpu, hlock_dma  in  1  locked-sequence request per master.
- haddr_cpu, haddr_dma  in  32  address.
- htrans_cpu, htrans_dma  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hburst_cpu, hburst_dma  in  3  burst type.
- hsize_cpu, hsize_dma  in  3  size.
- hprot_cpu, hprot_dma  in  4  protection.
- hwrite_cpu, hwrite_dma  in  1  write.
- hwdata_cpu, hwdata_dma  in  32  write data.
- hgrant_cpu, hgrant_dma  out  1  registered grant; exactly one is high.
- hmaster  out  1  address-phase owner: 0 = CPU, 1 = DMA.
- hmaster_data  out  1  data-phase owner.
- hmastlock_o  out  1  registered lock for the owner's transfer.
- haddr_o, htrans_o, hburst_o, hsize_o, hprot_o, hwrite_o  out  as inputs  owner's address/control; combinational mux on hmaster.
- hwdata_o  out  32  write data; combinational mux on hmaster_data.

## Operation
- FSM states:
  - ARB: grant may move at the next hready edge.
  - BURST: fixed-length burst in progress; grant frozen.
  - LOCK: owner holds hlock; grant frozen.
- Round-robin: a last-owner pointer breaks ties. If both masters request, grant the one that is not last-owner. If one requests, grant it. If none requests, park the grant on the CPU. A granted master keeps its grant while its hbusreq stays high and the other master is not requesting.
- Beat count is the length for hburst 010/011 = 4, 100/101 = 8, 110/111 = 16. Types 000 and 001 are undefined length and keep state ARB.
- ARB → BURST: at an hready edge where the owner's htrans is NONSEQ and the burst is fixed-length. Load count = length − 1.
- In BURST, each hready edge with owner htrans SEQ decrements the count. BUSY and IDLE hold it.
- BURST → ARB: at the edge where a SEQ beat is accepted with count = 1. Arbitration is evaluated at that same edge.
- An owner NONSEQ while in BURST (early termination) reloads the count from the new hburst.
- ARB/BURST → LOCK: at an hready edge where the owner's hlock = 1. Stay in LOCK while hlock = 1. Return to ARB at the first hready edge with hlock = 0; rearbitration happens at that edge.
- LOCK has priority over BURST.
- hmastlock_o is loaded at each hready edge from the owner's hlock.
- hmaster loads the granted master (hgrant_dma) at each hready edge. hmaster_data loads hmaster at each hready edge.
- When hready = 0, every register holds: grant, hmaster, hmaster_data, FSM state, count, pointer and hmastlock_o.

## Timing
- Reset values: hgrant_cpu = 1, hgrant_dma = 0, hmaster = 0, hmaster_data = 0, hmastlock_o = 0, state ARB, count 0, last-owner = CPU (so the first tie goes to DMA). Muxed outputs then follow the CPU inputs.
- Reset asserted mid-burst or mid-lock returns all of the above at the next edge, regardless of hready.
- Request-to-ownership latency with hready = 1 and state ARB:
  - hbusreq rises before edge N.
  - hgrant changes after edge N.
  - hmaster changes after edge N+1; the new owner's address is on haddr_o from then on.
  - hmaster_data follows after edge N+2.
- Address/control muxes have zero latency from hmaster. The data mux has zero latency from hmaster_data.
- The last beat of a fixed-length burst is accepted at edge M. The new grant is visible after M. The new owner drives the address after M+1.
- Simultaneous requests in the same cycle resolve by the pointer only. The pointer updates whenever hmaster changes.

## Test plan
- Reset, no requests: hgrant_cpu = 1, hmaster = 0. haddr_o tracks haddr_cpu = 0x0000_1000.
- Both request from idle after reset: hgrant_dma goes high 1 cycle later and hmaster = 1 one cycle after that. The DMA keeps requesting an undefined-length INCR; at the next hready edge the grant returns to the CPU (round-robin).
- DMA INCR8 to 0x2000_0000 with hready = 1 while the CPU requests: the grant stays DMA for all 8 beats. hgrant_cpu rises after the 8th beat. hwdata_o carries hwdata_dma through the 8th data phase, then hwdata_cpu.
- CPU INCR4 with hready low 2 cycles on beat 2: count, grant and hmaster hold. Burst completes after 4 accepted beats plus 2 stall cycles.
- CPU hlock = 1 across 3 transfers while the DMA requests: hmastlock_o = 1, grant held. The grant moves to the DMA at the first hready edge after hlock drops.
- Reset asserted mid-INCR16 at beat 7: next edge gives hgrant_cpu = 1, hmaster = 0, hmastlock_o = 0, state ARB.
